// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// One registered req/ack bus cycle per access, load extension, timeout.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_wordmode,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_exc,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] WM_WD = 3'd0;
    localparam logic [2:0] WM_HU = 3'd1;
    localparam logic [2:0] WM_HS = 3'd2;
    localparam logic [2:0] WM_BU = 3'd3;
    localparam logic [2:0] WM_BS = 3'd4;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [1:0]  lane;
    logic [2:0]  wm;
    logic        misal;
    logic        accept;
    logic        timeout;
    logic [31:0] wrep;
    logic [31:0] ext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Alignment check on the incoming request
    always_comb begin
        misal = 1'b0;
        case (req_wordmode)
            WM_WD:        misal = |req_addr[1:0];
            WM_HU, WM_HS: misal = req_addr[0];
            default:      misal = 1'b0;
        endcase
    end

    // Store data replicated onto every lane the access may use
    always_comb begin
        wrep = req_wdata;
        case (req_wordmode)
            WM_HU, WM_HS: wrep = {2{req_wdata[15:0]}};
            WM_BU, WM_BS: wrep = {4{req_wdata[7:0]}};
            default:      wrep = req_wdata;
        endcase
    end

    // Lane select and extension of the returned bus word
    always_comb begin
        rbyte = bus_rdata[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ext   = 32'd0;
        if (!bus_we) begin
            case (wm)
                WM_BU:   ext = {24'd0, rbyte};
                WM_BS:   ext = {{24{rbyte[7]}}, rbyte};
                WM_HU:   ext = {16'd0, rhalf};
                WM_HS:   ext = {{16{rhalf[15]}}, rhalf};
                default: ext = bus_rdata;
            endcase
        end
    end

    // Next state and pipeline-facing handshake outputs
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        timeout  = 1'b0;
        addr_exc = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                addr_exc = req_valid & misal;
                accept   = req_valid & ~misal;
                stall    = accept;
                if (accept) state_nx = BUSY;
            end
            BUSY: begin
                stall   = 1'b1;
                timeout = ~bus_ack & (cnt == TO_LAST);
                if (bus_ack || timeout) state_nx = RESP;
            end
            RESP: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Bus request capture; outputs stay frozen until the next accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            lane      <= 2'd0;
            wm        <= 3'd0;
        end else begin
            bus_req <= (state_nx == BUSY);
            if (accept) begin
                bus_we    <= req_we;
                bus_addr  <= {req_addr[31:2], 2'b00};
                bus_be    <= req_be;
                bus_wdata <= wrep;
                lane      <= req_addr[1:0];
                wm        <= req_wordmode;
            end
        end
    end

    // Wait-state counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        cnt <= 8'd0;
        else if (state != BUSY || bus_ack) cnt <= 8'd0;
        else if (!timeout)                 cnt <= cnt + 8'd1;
        else                               cnt <= 8'd0;
    end

    // Response data and error flag, presented during RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata   <= 32'd0;
            bus_err <= 1'b0;
        end else if (state == BUSY && bus_ack) begin
            rdata   <= ext;
            bus_err <= 1'b0;
        end else if (timeout) begin
            rdata   <= 32'd0;
            bus_err <= 1'b1;
        end else if (state == RESP) begin
            bus_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit.
// Built with a 4-cycle timeout so the abandon path is short.
module tb_mem_access_unit;

    localparam logic [2:0] WM_WD = 3'd0;
    localparam logic [2:0] WM_HU = 3'd1;
    localparam logic [2:0] WM_HS = 3'd2;
    localparam logic [2:0] WM_BU = 3'd3;
    localparam logic [2:0] WM_BS = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_wordmode = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, done, addr_exc, bus_err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int failures = 0;

    int          a_stalls, a_reqs;
    logic        a_we, a_err, a_done;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    int          seen;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wordmode(req_wordmode),
        .req_be(req_be), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata),
        .addr_exc(addr_exc), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access; ack on BUSY cycle index 'waits' (negative = never)
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [2:0] wm, input logic [3:0] be,
                          input logic [31:0] wd, input int waits,
                          input logic [31:0] rd);
        int k;
        req_we = we; req_addr = addr; req_wordmode = wm;
        req_be = be; req_wdata = wd; req_valid = 1'b1;
        #1;
        a_stalls = 0; a_reqs = 0; a_done = 1'b0; k = 0;
        a_rdata = 'x; a_err = 1'bx;
        for (int c = 0; c < 40 && !a_done; c++) begin
            if (stall) a_stalls++;
            if (bus_req) begin
                if (k == 0) begin
                    a_we = bus_we; a_addr = bus_addr;
                    a_be = bus_be; a_wdata = bus_wdata;
                end
                a_reqs++;
                bus_rdata = rd;
                bus_ack = (k == waits);
                k++;
            end
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            #1;
            if (done) begin
                a_done = 1'b1;
                a_rdata = rdata;
                a_err = bus_err;
            end
        end
        chk("done_seen", 32'(a_done), 32'd1);
        chk("stall_at_done", 32'(stall), 32'd0);
        chk("req_at_done", 32'(bus_req), 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        step();

        access(1'b1, 32'h0000_1004, WM_WD, 4'b1111, 32'hDEADBEEF, 0, 32'h0);
        chk("sw_addr", a_addr, 32'h0000_1004);
        chk("sw_wdata", a_wdata, 32'hDEADBEEF);
        chk("sw_we", 32'(a_we), 32'd1);
        chk("sw_be", 32'(a_be), 32'hF);
        chk("sw_stalls", 32'(a_stalls), 32'd2);
        chk("sw_rdata", a_rdata, 32'd0);
        chk("sw_err", 32'(a_err), 32'd0);
        step();

        access(1'b0, 32'h0000_1003, WM_BS, 4'b1000, 32'h0, 3, 32'h80FF_1234);
        chk("lbs_rdata", a_rdata, 32'hFFFF_FF80);
        chk("lbs_addr", a_addr, 32'h0000_1000);
        chk("lbs_we", 32'(a_we), 32'd0);
        chk("lbs_stalls", 32'(a_stalls), 32'd5);
        chk("lbs_err", 32'(a_err), 32'd0);
        step();

        access(1'b0, 32'h0000_1003, WM_BU, 4'b1000, 32'h0, 3, 32'h80FF_1234);
        chk("lbu_rdata", a_rdata, 32'h0000_0080);
        step();

        access(1'b0, 32'h0000_1002, WM_HS, 4'b1100, 32'h0, 1, 32'h9ABC_0000);
        chk("lhs_rdata", a_rdata, 32'hFFFF_9ABC);
        chk("lhs_stalls", 32'(a_stalls), 32'd3);
        step();

        access(1'b0, 32'h0000_2000, WM_WD, 4'b1111, 32'h0, -1, 32'h55AA_55AA);
        chk("to_reqs", 32'(a_reqs), 32'd4);
        chk("to_stalls", 32'(a_stalls), 32'd5);
        chk("to_err", 32'(a_err), 32'd1);
        chk("to_rdata", a_rdata, 32'd0);
        step();
        chk("to_idle_req", 32'(bus_req), 32'd0);
        chk("to_idle_err", 32'(bus_err), 32'd0);
        chk("to_idle_done", 32'(done), 32'd0);

        access(1'b1, 32'h0000_1002, WM_HU, 4'b1100, 32'h1234_5678, 0, 32'h0);
        chk("shu_wdata", a_wdata, 32'h5678_5678);
        chk("shu_be", 32'(a_be), 32'b1100);
        chk("shu_addr", a_addr, 32'h0000_1000);
        step();

        access(1'b1, 32'h0000_1001, WM_BU, 4'b0010, 32'h0000_00A5, 0, 32'h0);
        chk("sb_wdata", a_wdata, 32'hA5A5_A5A5);
        step();

        req_we = 1'b0; req_addr = 32'h0000_1001;
        req_wordmode = WM_WD; req_be = 4'hF; req_valid = 1'b1;
        #1;
        chk("mis_exc", 32'(addr_exc), 32'd1);
        chk("mis_stall", 32'(stall), 32'd0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus_req || stall || done) seen++;
        end
        chk("mis_nobus", 32'(seen), 32'd0);
        req_addr = 32'h0000_1003; req_wordmode = WM_HS;
        #1;
        chk("mis_half", 32'(addr_exc), 32'd1);
        req_wordmode = WM_BS;
        #1;
        chk("byte_ok_exc", 32'(addr_exc), 32'd0);
        chk("byte_ok_stall", 32'(stall), 32'd1);
        req_valid = 1'b0;
        #1;
        chk("exc_idle", 32'(addr_exc), 32'd0);
        step();

        req_we = 1'b0; req_addr = 32'h0000_4000;
        req_wordmode = WM_WD; req_valid = 1'b1;
        step();
        step();
        chk("mid_req", 32'(bus_req), 32'd1);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_req", 32'(bus_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_addr", bus_addr, 32'd0);
        step();
        step();
        chk("arst_nodone", 32'(done), 32'd0);
        #2;
        reset = 1'b1;
        step();

        access(1'b0, 32'h0000_3000, WM_WD, 4'hF, 32'h0, 1, 32'h0BAD_F00D);
        chk("post_rdata", a_rdata, 32'h0BAD_F00D);
        chk("post_err", 32'(a_err), 32'd0);
        step();

        bus_rdata = 32'hFFFF_FFFF;
        bus_ack = 1'b1;
        step();
        chk("spur_done", 32'(done), 32'd0);
        chk("spur_req", 32'(bus_req), 32'd0);
        chk("spur_stall", 32'(stall), 32'd0);
        bus_ack = 1'b0;
        step();
        chk("spur_rdata", rdata, 32'h0BAD_F00D);
        chk("spur_done2", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
